// File: rtl/memory_turn_ctrl.sv
// Turn controller for the memory-pairs game: two picks per turn, match scoring,
// player rotation on mismatch or timeout, and winner/tie detection at game end.
module memory_turn_ctrl #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_PAIRS   = 8,
  parameter int VAL_W       = 4,
  parameter int IDX_W       = 8,
  parameter int SCORE_W     = 8,
  parameter int PAIR_W      = 8,
  localparam int PW         = (NUM_PLAYERS < 2) ? 1 : $clog2(NUM_PLAYERS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           new_game,
  input  logic                           pick_valid,
  input  logic [IDX_W-1:0]               pick_idx,
  input  logic [VAL_W-1:0]               pick_val,
  input  logic                           time_up,
  output logic                           pick_ready,
  output logic [PW-1:0]                  player,
  output logic [IDX_W-1:0]               sel1_idx,
  output logic [IDX_W-1:0]               sel2_idx,
  output logic                           result_valid,
  output logic                           match,
  output logic                           timeout,
  output logic                           dup_err,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [PAIR_W-1:0]              pairs_found,
  output logic                           game_over,
  output logic [PW-1:0]                  winner,
  output logic                           tie
);

  localparam logic [1:0] S_FIRST  = 2'd0;
  localparam logic [1:0] S_SECOND = 2'd1;
  localparam logic [1:0] S_EVAL   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [PW-1:0]      LAST_PLAYER = PW'(NUM_PLAYERS - 1);
  localparam logic [PAIR_W-1:0]  PAIRS_TOTAL = PAIR_W'(NUM_PAIRS);
  localparam logic [PAIR_W-1:0]  PAIR_ONE    = PAIR_W'(1);
  localparam logic [SCORE_W-1:0] SCORE_ONE   = SCORE_W'(1);

  function automatic logic [PW-1:0] next_player(input logic [PW-1:0] p);
    return (p == LAST_PLAYER) ? '0 : p + PW'(1);
  endfunction

  logic [1:0]         r_state;
  logic               r_armed;
  logic [PW-1:0]      r_player;
  logic [IDX_W-1:0]   r_sel1;
  logic [IDX_W-1:0]   r_sel2;
  logic [VAL_W-1:0]   r_v1;
  logic [VAL_W-1:0]   r_v2;
  logic               r_result_valid;
  logic               r_match;
  logic               r_timeout;
  logic               r_dup;
  logic [SCORE_W-1:0] r_score [NUM_PLAYERS];
  logic [PAIR_W-1:0]  r_pairs;

  // r_armed keeps every output, pick_ready included, at 0 for the cycle after a clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state        <= S_FIRST;
      r_armed        <= 1'b0;
      r_player       <= '0;
      r_sel1         <= '0;
      r_sel2         <= '0;
      r_v1           <= '0;
      r_v2           <= '0;
      r_result_valid <= 1'b0;
      r_match        <= 1'b0;
      r_timeout      <= 1'b0;
      r_dup          <= 1'b0;
      r_pairs        <= '0;
      for (int k = 0; k < NUM_PLAYERS; k++) r_score[k] <= '0;
    end else if (new_game) begin
      r_state        <= S_FIRST;
      r_armed        <= 1'b0;
      r_player       <= '0;
      r_sel1         <= '0;
      r_sel2         <= '0;
      r_v1           <= '0;
      r_v2           <= '0;
      r_result_valid <= 1'b0;
      r_match        <= 1'b0;
      r_timeout      <= 1'b0;
      r_dup          <= 1'b0;
      r_pairs        <= '0;
      for (int k = 0; k < NUM_PLAYERS; k++) r_score[k] <= '0;
    end else begin
      r_armed        <= 1'b1;
      r_result_valid <= 1'b0;
      r_timeout      <= 1'b0;
      r_dup          <= 1'b0;
      case (r_state)
        S_FIRST: begin
          if (r_armed) begin
            if (pick_valid) begin
              r_sel1  <= pick_idx;
              r_v1    <= pick_val;
              r_state <= S_SECOND;
            end else if (time_up) begin
              r_timeout <= 1'b1;
              r_player  <= next_player(r_player);
            end
          end
        end
        S_SECOND: begin
          if (pick_valid) begin
            if (pick_idx == r_sel1) begin
              r_dup <= 1'b1;
            end else begin
              r_sel2  <= pick_idx;
              r_v2    <= pick_val;
              r_state <= S_EVAL;
            end
          end else if (time_up) begin
            r_timeout <= 1'b1;
            r_player  <= next_player(r_player);
            r_state   <= S_FIRST;
          end
        end
        S_EVAL: begin
          r_result_valid <= 1'b1;
          if (r_v1 == r_v2) begin
            r_match           <= 1'b1;
            r_score[r_player] <= r_score[r_player] + SCORE_ONE;
            r_pairs           <= r_pairs + PAIR_ONE;
            r_state           <= (r_pairs + PAIR_ONE == PAIRS_TOTAL) ? S_DONE : S_FIRST;
          end else begin
            r_match  <= 1'b0;
            r_player <= next_player(r_player);
            r_state  <= S_FIRST;
          end
        end
        default: ;
      endcase
    end
  end

  // strict '>' keeps the lowest-index holder of the maximum as winner
  logic [SCORE_W-1:0] w_max;
  logic [PW-1:0]      w_winner;
  logic               w_tie;

  always_comb begin
    w_max    = r_score[0];
    w_winner = '0;
    w_tie    = 1'b0;
    for (int k = 1; k < NUM_PLAYERS; k++) begin
      if (r_score[k] > w_max) begin
        w_max    = r_score[k];
        w_winner = PW'(k);
        w_tie    = 1'b0;
      end else if (r_score[k] == w_max) begin
        w_tie = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_score
    assign score[g*SCORE_W +: SCORE_W] = r_score[g];
  end

  assign game_over    = (r_state == S_DONE);
  assign pick_ready   = r_armed & ((r_state == S_FIRST) | (r_state == S_SECOND));
  assign player       = r_player;
  assign sel1_idx     = r_sel1;
  assign sel2_idx     = r_sel2;
  assign result_valid = r_result_valid;
  assign match        = r_match;
  assign timeout      = r_timeout;
  assign dup_err      = r_dup;
  assign pairs_found  = r_pairs;
  assign winner       = game_over ? w_winner : '0;
  assign tie          = game_over & w_tie;

endmodule

// File: tb/tb_memory_turn_ctrl.sv
// Directed bench for memory_turn_ctrl: 3 players, 2 pairs, hand-computed expectations.
module tb_memory_turn_ctrl;
  localparam int NP      = 3;
  localparam int NPAIRS  = 2;
  localparam int VAL_W   = 4;
  localparam int IDX_W   = 8;
  localparam int SCORE_W = 8;
  localparam int PAIR_W  = 8;
  localparam int PW      = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      new_game;
  logic                      pick_valid;
  logic [IDX_W-1:0]          pick_idx;
  logic [VAL_W-1:0]          pick_val;
  logic                      time_up;
  logic                      pick_ready;
  logic [PW-1:0]             player;
  logic [IDX_W-1:0]          sel1_idx;
  logic [IDX_W-1:0]          sel2_idx;
  logic                      result_valid;
  logic                      match;
  logic                      timeout;
  logic                      dup_err;
  logic [NP*SCORE_W-1:0]     score;
  logic [PAIR_W-1:0]         pairs_found;
  logic                      game_over;
  logic [PW-1:0]             winner;
  logic                      tie;

  int n_checks = 0;
  int n_fail   = 0;

  memory_turn_ctrl #(
    .NUM_PLAYERS(NP), .NUM_PAIRS(NPAIRS), .VAL_W(VAL_W),
    .IDX_W(IDX_W), .SCORE_W(SCORE_W), .PAIR_W(PAIR_W)
  ) dut (
    .clk(clk), .rst(rst), .new_game(new_game),
    .pick_valid(pick_valid), .pick_idx(pick_idx), .pick_val(pick_val),
    .time_up(time_up), .pick_ready(pick_ready), .player(player),
    .sel1_idx(sel1_idx), .sel2_idx(sel2_idx), .result_valid(result_valid),
    .match(match), .timeout(timeout), .dup_err(dup_err), .score(score),
    .pairs_found(pairs_found), .game_over(game_over), .winner(winner), .tie(tie)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pick(input logic [IDX_W-1:0] i, input logic [VAL_W-1:0] v);
    pick_valid = 1'b1;
    pick_idx   = i;
    pick_val   = v;
    tick();
    pick_valid = 1'b0;
  endtask

  // two picks plus the EVAL cycle; results are visible on return
  task automatic turn(input logic [IDX_W-1:0] i1, input logic [VAL_W-1:0] v1,
                      input logic [IDX_W-1:0] i2, input logic [VAL_W-1:0] v2);
    pick(i1, v1);
    pick(i2, v2);
    tick();
  endtask

  task automatic restart();
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b0; new_game = 1'b0; pick_valid = 1'b0;
    pick_idx = '0; pick_val = '0; time_up = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_pick_ready", pick_ready, 0);
    check_eq("rst_player", player, 0);
    check_eq("rst_score", score, 0);
    check_eq("rst_pairs", pairs_found, 0);
    check_eq("rst_flags", {result_valid, match, timeout, dup_err, game_over, tie}, 0);
    check_eq("rst_winner", winner, 0);
    check_eq("rst_sel", {sel1_idx, sel2_idx}, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_eq("arm_pick_ready", pick_ready, 1);
    check_eq("arm_player", player, 0);

    pick(8'd3, 4'd5);
    check_eq("m_sel1", sel1_idx, 3);
    check_eq("m_ready_second", pick_ready, 1);
    pick(8'd9, 4'd5);
    check_eq("m_sel2", sel2_idx, 9);
    check_eq("m_ready_eval", pick_ready, 0);
    check_eq("m_rv_eval", result_valid, 0);
    tick();
    check_eq("m_rv", result_valid, 1);
    check_eq("m_match", match, 1);
    check_eq("m_score", score, 24'h000001);
    check_eq("m_pairs", pairs_found, 1);
    check_eq("m_player", player, 0);
    check_eq("m_ready_back", pick_ready, 1);
    check_eq("m_game_over", game_over, 0);
    tick();
    check_eq("m_rv_fall", result_valid, 0);

    restart();
    turn(8'd1, 4'd1, 8'd2, 4'd2);
    check_eq("mm1_rv", result_valid, 1);
    check_eq("mm1_match", match, 0);
    check_eq("mm1_player", player, 1);
    turn(8'd3, 4'd3, 8'd4, 4'd4);
    check_eq("mm2_player", player, 2);
    turn(8'd5, 4'd5, 8'd6, 4'd6);
    check_eq("mm3_player_wrap", player, 0);
    check_eq("mm_score", score, 0);
    check_eq("mm_pairs", pairs_found, 0);

    pick(8'd4, 4'd1);
    pick(8'd4, 4'd2);
    check_eq("dup_err", dup_err, 1);
    check_eq("dup_ready", pick_ready, 1);
    check_eq("dup_sel2_kept", sel2_idx, 6);
    tick();
    check_eq("dup_fall", dup_err, 0);
    time_up = 1'b1;
    tick();
    time_up = 1'b0;
    check_eq("to_pulse", timeout, 1);
    check_eq("to_player", player, 1);
    check_eq("to_sel2_kept", sel2_idx, 6);
    tick();
    check_eq("to_fall", timeout, 0);

    pick_valid = 1'b1; pick_idx = 8'd7; pick_val = 4'd3; time_up = 1'b1;
    tick();
    pick_valid = 1'b0; time_up = 1'b0;
    check_eq("sim_sel1", sel1_idx, 7);
    check_eq("sim_no_timeout", timeout, 0);
    check_eq("sim_player", player, 1);
    pick(8'd8, 4'd4);
    tick();
    check_eq("sim_turn_player", player, 2);
    check_eq("sim_turn_match", match, 0);

    restart();
    turn(8'd0, 4'd1, 8'd1, 4'd1);
    check_eq("g0_pairs1", pairs_found, 1);
    check_eq("g0_not_over", game_over, 0);
    turn(8'd2, 4'd2, 8'd3, 4'd2);
    check_eq("g0_rv", result_valid, 1);
    check_eq("g0_over", game_over, 1);
    check_eq("g0_pairs", pairs_found, 2);
    check_eq("g0_score", score, 24'h000002);
    check_eq("g0_winner", winner, 0);
    check_eq("g0_tie", tie, 0);
    check_eq("g0_ready", pick_ready, 0);
    pick_valid = 1'b1; pick_idx = 8'd9; pick_val = 4'd9; time_up = 1'b1;
    tick();
    pick_valid = 1'b0; time_up = 1'b0;
    tick();
    check_eq("g0_ignore_sel1", sel1_idx, 2);
    check_eq("g0_ignore_to", timeout, 0);
    check_eq("g0_still_over", game_over, 1);
    check_eq("g0_ignore_pairs", pairs_found, 2);

    restart();
    turn(8'd0, 4'd1, 8'd1, 4'd2);
    check_eq("g1_player", player, 1);
    turn(8'd2, 4'd3, 8'd3, 4'd3);
    check_eq("g1_score_mid", score, 24'h000100);
    check_eq("g1_player_keep", player, 1);
    turn(8'd4, 4'd4, 8'd5, 4'd4);
    check_eq("g1_over", game_over, 1);
    check_eq("g1_winner", winner, 1);
    check_eq("g1_tie", tie, 0);
    check_eq("g1_score", score, 24'h000200);

    restart();
    turn(8'd0, 4'd1, 8'd1, 4'd1);
    turn(8'd2, 4'd2, 8'd3, 4'd3);
    check_eq("gt_player", player, 1);
    turn(8'd4, 4'd4, 8'd5, 4'd4);
    check_eq("gt_over", game_over, 1);
    check_eq("gt_score", score, 24'h000101);
    check_eq("gt_tie", tie, 1);
    check_eq("gt_winner", winner, 0);

    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    check_eq("ng_score", score, 0);
    check_eq("ng_pairs", pairs_found, 0);
    check_eq("ng_over", {game_over, tie}, 0);
    check_eq("ng_player", player, 0);
    tick();
    check_eq("ng_ready", pick_ready, 1);

    pick(8'd11, 4'd1);
    check_eq("ar_sel1_pre", sel1_idx, 11);
    #2 rst = 1'b0;
    #1;
    check_eq("ar_sel1", sel1_idx, 0);
    check_eq("ar_ready", pick_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check_eq("ar_ready_back", pick_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/memory_turn_ctrl.md
# memory_turn_ctrl

Parametrised turn controller for the memory-pairs game. It accepts two card picks per turn, compares their values and scores matches for the current player. It rotates the turn among N players on a mismatch or timeout, and declares a winner or tie when all pairs are found. It sits between the card-selection/timer logic and the display/score FSM, and supersedes the fixed 2-player, 8-pair turn logic.

## Interface
- NUM_PLAYERS, 2, number of players (2..8); PW = max(1, $clog2(NUM_PLAYERS))
- NUM_PAIRS, 8, pairs on the board; game ends when all are found
- VAL_W, 4, card value width
- IDX_W, 8, card position index width
- SCORE_W, 8, per-player score width; must hold NUM_PAIRS
- PAIR_W, 8, width of pairs_found; must hold NUM_PAIRS
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-low
- new_game  in  1  synchronous restart pulse; same effect as reset
- pick_valid  in  1  a card pick is presented this cycle
- pick_idx  in  IDX_W  position of picked card
- pick_val  in  VAL_W  value of picked card
- time_up  in  1  turn timer expired
- pick_ready  out  1  high in FIRST or SECOND; picks are accepted only then
- player  out  PW  current player, 0..NUM_PLAYERS-1
- sel1_idx, sel2_idx  out  IDX_W  latched first and second pick positions
- result_valid  out  1  one-cycle pulse: turn evaluated
- match  out  1  qualified by result_valid: the two values were equal
- timeout  out  1  one-cycle pulse: turn forfeited by time_up
- dup_err  out  1  one-cycle pulse: second pick equals first position, rejected
- score  out  NUM_PLAYERS*SCORE_W  flattened scores, player k at [k*SCORE_W +: SCORE_W]
- pairs_found  out  PAIR_W  total matched pairs
- game_over  out  1  high in DONE
- winner  out  PW  lowest-index player holding the max score; valid when game_over
- tie  out  1  more than one player holds the max score; valid when game_over

## Operation
- The FSM has four states: FIRST, SECOND, EVAL and DONE.
- Reset and new_game put the block in FIRST with all registers cleared.
  - After reset, every output is 0.
  - pick_ready returns 1 in the first cycle after reset.
- FIRST:
  - pick_valid latches pick_idx into sel1_idx and pick_val into v1, then moves to SECOND.
  - time_up alone pulses timeout, advances player, and stays in FIRST.
- SECOND:
  - pick_valid with pick_idx == sel1_idx pulses dup_err; the FSM stays in SECOND and nothing is latched.
  - Otherwise pick_valid latches sel2_idx and v2, then moves to EVAL.
  - time_up alone pulses timeout, advances player, and returns to FIRST. No score changes.
- EVAL lasts exactly one cycle and is the only state that changes scores.
  - If v1 == v2: score[player] += 1, pairs_found += 1, match=1, and player is unchanged (the same player goes again).
  - Otherwise: match=0 and player advances.
  - result_valid pulses on the cycle after EVAL.
  - The next state is DONE if the incremented pairs_found == NUM_PAIRS; otherwise FIRST.
- Player advance: player = (player == NUM_PLAYERS-1) ? 0 : player+1.
- DONE:
  - game_over=1; winner and tie are computed combinationally from score.
  - Picks and time_up are ignored; the FSM stays until rst or new_game.
- Simultaneous events:
  - pick_valid and time_up in the same cycle: the pick wins and time_up is ignored.
  - new_game has priority over everything except rst.
- Inputs are ignored in EVAL. sel1_idx and sel2_idx hold their values until overwritten.
- Scores never wrap, because SCORE_W holds NUM_PAIRS.

## Timing
- A pick is accepted at the rising edge where pick_valid=1 and pick_ready=1.
- Second pick accepted at edge N: EVAL during cycle N→N+1.
  - At edge N+1, score, pairs_found, player and match update, and result_valid rises.
  - result_valid falls at N+2.
  - pick_ready returns at N+1, or stays low if the FSM enters DONE.
- timeout and dup_err are registered; each is high for the one cycle after the edge that sampled the event.
- game_over rises at edge N+1 of the final matching turn, together with result_valid.
- Asserting rst mid-turn clears everything immediately. It is deasserted synchronously with clk.

## Test plan
- Reset: rst=0 then 1 -> all outputs 0, pick_ready=1 next cycle, player=0.
- Match: P0 picks (idx3,val5), then (idx9,val5) -> result_valid=1 and match=1 one cycle after EVAL, score[0]=1, pairs_found=1, player stays 0.
- Mismatch and wrap, NUM_PLAYERS=3, three mismatching turns starting at player 0:
  - player sequence 0 -> 1 -> 2 -> 0;
  - scores stay 0.
- Duplicate and timeout:
  - picks idx4 then idx4 -> dup_err one cycle, state remains SECOND;
  - then time_up -> timeout pulse, player advances, back to FIRST, sel2 not latched.
- Simultaneous: pick_valid and time_up in the same cycle in FIRST -> pick latched, no timeout.
- Game end, NUM_PAIRS=2, both pairs found:
  - P0 finds both -> game_over=1, winner=0, tie=0;
  - one pair each -> tie=1, winner=0;
  - any further picks ignored; new_game -> FIRST with scores cleared.
